dmem_arbiter: RTL and testbench

Arbitrates the single-port data memory between the pipeline MEM stage and an external requester (debug/loader/DMA port). The CPU has priority, but an external request that is starved for STARVE_LIMIT cycles forces a bounded external burst, during which the pipeline is stalled. The block sits between the EX/MEM pipeline register outputs and the data memory. It routes the 1-cycle-latency read data back to whichever requester issued the read.

---
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the MEM stage and an external requester.
// The CPU has priority; a starved external request forces a bounded external burst.
module dmem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_valid,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ready,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WCW = $clog2(STARVE_LIMIT + 1);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {S_CPU, S_EXT} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [BCW-1:0]    burst_q, burst_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic cpu_req, cpu_is_rd, grant_cpu, grant_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CPU;
            owner_q <= OWN_NONE;
            wait_q  <= '0;
            burst_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
            burst_q <= burst_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        cpu_req   = cpu_rd | cpu_wr;
        cpu_is_rd = cpu_rd & ~cpu_wr;
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        state_d   = state_q;
        wait_d    = wait_q;
        burst_d   = burst_q;
        unique case (state_q)
            S_CPU: begin
                if (cpu_req)        grant_cpu = 1'b1;
                else if (ext_valid) grant_ext = 1'b1;
                if (ext_valid && !grant_ext) begin
                    if (int'(wait_q) < STARVE_LIMIT) wait_d = wait_q + 1'b1;
                    if (int'(wait_q) + 1 >= STARVE_LIMIT) state_d = S_EXT;
                end else begin
                    wait_d = '0;
                end
            end
            S_EXT: begin
                wait_d = '0;
                if (ext_valid) begin
                    grant_ext = 1'b1;
                    if (int'(burst_q) + 1 >= MAX_BURST) begin
                        state_d = S_CPU;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    // External side went idle: hand the cycle straight back to the CPU.
                    grant_cpu = cpu_req;
                    state_d   = S_CPU;
                    burst_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (grant_cpu && cpu_is_rd)    owner_d = OWN_CPU;
        else if (grant_ext && !ext_we) owner_d = OWN_EXT;
        hold_d = (owner_q == OWN_CPU) ? mem_rdata : hold_q;
    end

    always_comb begin
        mem_wr     = rst_n & (grant_cpu ? cpu_wr    : (grant_ext & ext_we));
        mem_rd     = rst_n & (grant_cpu ? cpu_is_rd : (grant_ext & ~ext_we));
        mem_addr   = grant_ext ? ext_addr  : cpu_addr;
        mem_wdata  = grant_ext ? ext_wdata : cpu_wdata;
        cpu_stall  = rst_n & cpu_req & ~grant_cpu;
        ext_ready  = rst_n & ext_valid & grant_ext;
        ext_rvalid = rst_n & (owner_q == OWN_EXT);
        ext_rdata  = mem_rdata;
        if (!rst_n)                  cpu_rdata = '0;
        else if (owner_q == OWN_CPU) cpu_rdata = mem_rdata;
        else                         cpu_rdata = hold_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural priority model.
module tb_dmem_arbiter;

    localparam int ADDR_W       = 14;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_rd, cpu_wr, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              ext_valid, ext_we, ext_ready, ext_rvalid;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata, ext_rdata;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: "forced" means the external side currently owns priority.
    bit                m_forced;
    int                m_denied;     // consecutive cycles the ext request was refused
    int                m_granted;    // ext grants during the current forced episode
    int                m_ret;        // 0 none, 1 cpu read returns now, 2 ext read returns now
    logic [DATA_W-1:0] m_hold;
    bit                last_stall, last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_forced = 0; m_denied = 0; m_granted = 0; m_ret = 0; m_hold = '0;
        last_stall = 0; last_ready = 0;
    endtask

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; ext_valid = 0; ext_we = 0;
        cpu_addr = '0; cpu_wdata = '0; ext_addr = '0; ext_wdata = '0;
    endtask

    // Compare one cycle against the model, advance across the rising edge, end at the next falling edge.
    task automatic step();
        bit creq, gc, ge, exp_rd, exp_wr;
        #1;
        if (!rst_n) begin
            chk("rst_mem_rd", mem_rd, 0);
            chk("rst_mem_wr", mem_wr, 0);
            chk("rst_cpu_stall", cpu_stall, 0);
            chk("rst_ext_ready", ext_ready, 0);
            chk("rst_ext_rvalid", ext_rvalid, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            model_reset();
            @(posedge clk);
            @(negedge clk);
            mem_rdata = $urandom;
            return;
        end
        creq = cpu_rd | cpu_wr;
        if (m_forced) begin ge = ext_valid; gc = !ext_valid && creq; end
        else          begin gc = creq;      ge = !creq && ext_valid; end
        exp_wr = gc ? cpu_wr : (ge && ext_we);
        exp_rd = gc ? (cpu_rd && !cpu_wr) : (ge && !ext_we);
        chk("cpu_stall", cpu_stall, creq && !gc);
        chk("ext_ready", ext_ready, ge);
        chk("mem_wr", mem_wr, exp_wr);
        chk("mem_rd", mem_rd, exp_rd);
        if (exp_rd || exp_wr) chk("mem_addr", 32'(mem_addr), gc ? 32'(cpu_addr) : 32'(ext_addr));
        if (exp_wr)           chk("mem_wdata", mem_wdata, gc ? cpu_wdata : ext_wdata);
        chk("cpu_rdata", cpu_rdata, (m_ret == 1) ? mem_rdata : m_hold);
        chk("ext_rvalid", ext_rvalid, m_ret == 2);
        if (m_ret == 2) chk("ext_rdata", ext_rdata, mem_rdata);
        last_stall = creq && !gc;
        last_ready = ge;
        @(posedge clk);
        if (m_ret == 1) m_hold = mem_rdata;
        m_ret = (gc && cpu_rd && !cpu_wr) ? 1 : ((ge && !ext_we) ? 2 : 0);
        if (!m_forced) begin
            if (ext_valid && !ge) begin
                m_denied++;
                if (m_denied >= STARVE_LIMIT) begin m_forced = 1; m_denied = 0; m_granted = 0; end
            end else begin
                m_denied = 0;
            end
        end else if (!ext_valid) begin
            m_forced = 0; m_granted = 0; m_denied = 0;
        end else begin
            m_granted++;
            if (m_granted >= MAX_BURST) begin m_forced = 0; m_granted = 0; m_denied = 0; end
        end
        @(negedge clk);
        mem_rdata = $urandom;
    endtask

    initial begin
        int r;
        idle_inputs();
        mem_rdata = '0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        step();
        step();
        rst_n = 1;

        // CPU read with known memory data
        cpu_rd = 1; cpu_addr = 14'h0010;
        #1 chk("t1_mem_rd", mem_rd, 1);
        chk("t1_addr", 32'(mem_addr), 32'h10);
        step();
        cpu_rd = 0; mem_rdata = 32'hDEADBEEF;
        #1 chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        step();
        #1 chk("t1_hold", cpu_rdata, 32'hDEADBEEF);
        step();

        // External write while CPU idle
        ext_valid = 1; ext_we = 1; ext_addr = 14'h0020; ext_wdata = 32'h12345678;
        #1 chk("t2_ready", ext_ready, 1);
        chk("t2_wr", mem_wr, 1);
        chk("t2_addr", 32'(mem_addr), 32'h20);
        chk("t2_wdata", mem_wdata, 32'h12345678);
        step();
        ext_valid = 0; ext_we = 0;
        #1 chk("t2_no_rvalid", ext_rvalid, 0);
        step();

        // Continuous contention: four CPU cycles, two forced ext cycles, back to CPU
        cpu_rd = 1; cpu_addr = 14'h0100; ext_valid = 1; ext_addr = 14'h0200;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c <= 6) begin
                chk("t3_ready", ext_ready, (c == 4 || c == 5));
                chk("t3_stall", cpu_stall, (c == 4 || c == 5));
            end
            chk("t3_rvalid", ext_rvalid, (c == 5 || c == 6));
            step();
        end
        idle_inputs();
        step();
        step();

        // Alternating owners: CPU read, then forced ext read
        cpu_rd = 1; cpu_addr = 14'h0011; ext_valid = 1; ext_addr = 14'h0022;
        for (int c = 0; c < 3; c++) step();
        #1 chk("t4_c0_cpu", mem_rd & ~cpu_stall, 1);
        step();
        mem_rdata = 32'hAAAA0001;
        #1 chk("t4_c1_ext", ext_ready, 1);
        chk("t4_c1_rdata", cpu_rdata, 32'hAAAA0001);
        chk("t4_c1_rvalid", ext_rvalid, 0);
        step();
        ext_valid = 0; mem_rdata = 32'hBBBB0002;
        #1 chk("t4_c2_rvalid", ext_rvalid, 1);
        chk("t4_c2_erdata", ext_rdata, 32'hBBBB0002);
        chk("t4_c2_rdata", cpu_rdata, 32'hAAAA0001);
        step();
        cpu_rd = 0; mem_rdata = 32'hCCCC0003;
        #1 chk("t4_c3_rvalid", ext_rvalid, 0);
        chk("t4_c3_rdata", cpu_rdata, 32'hCCCC0003);
        step();

        // Read and write together behave as a write with no return
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 14'h0033; cpu_wdata = 32'h0BADF00D;
        #1 chk("t5_wr", mem_wr, 1);
        chk("t5_rd", mem_rd, 0);
        step();
        idle_inputs(); mem_rdata = 32'h55555555;
        #1 chk("t5_no_return", cpu_rdata, 32'hCCCC0003);
        step();

        // Reset during a forced ext read in flight
        cpu_rd = 1; cpu_addr = 14'h0044; ext_valid = 1; ext_addr = 14'h0055;
        for (int c = 0; c < 4; c++) step();
        #1 chk("t6_ext_granted", ext_ready, 1);
        #2 rst_n = 0;
        #1 chk("t6_rst_rvalid", ext_rvalid, 0);
        chk("t6_rst_mem_rd", mem_rd, 0);
        chk("t6_rst_stall", cpu_stall, 0);
        model_reset();
        @(posedge clk);
        #1 chk("t6_rst_rvalid2", ext_rvalid, 0);
        chk("t6_rst_rdata", cpu_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("t6_post_stall", cpu_stall, 0);
        chk("t6_post_rvalid", ext_rvalid, 0);
        chk("t6_post_ready", ext_ready, 0);
        step();
        idle_inputs();
        step();

        // Randomized traffic honouring the hold-until-accepted rules
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                r = $urandom_range(0, 7);
                cpu_rd    = (r == 1 || r == 2 || r == 7);
                cpu_wr    = (r == 3 || r == 4 || r == 7);
                cpu_addr  = ADDR_W'($urandom);
                cpu_wdata = $urandom;
            end
            if (ext_valid && !last_ready) begin
                if ($urandom_range(0, 15) == 0) ext_valid = 0;
            end else begin
                ext_valid = ($urandom_range(0, 2) != 0);
                ext_we    = $urandom_range(0, 1) == 1;
                ext_addr  = ADDR_W'($urandom);
                ext_wdata = $urandom;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
